// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared tug-of-war types, winner codes and seven-segment table
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    CLEAR      = 2'd2,
    MATCH_OVER = 2'd3
  } match_state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Active-low segments {g,f,e,d,c,b,a}; shared with the other HEX drivers on the board.
  localparam logic [6:0] SEG_DIGIT [0:7] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
  };

endpackage

// File: rtl/match_controller_if.sv
// rtl/match_controller_if.sv - round-result inputs and display outputs of the match sequencer
interface match_controller_if;
  logic       win_p1;
  logic       win_p2;
  logic       start;
  logic       round_reset;
  logic       match_over;
  logic [1:0] winner;
  logic [6:0] hex_p1;
  logic [6:0] hex_p2;

  modport master (
    output win_p1, win_p2, start,
    input  round_reset, match_over, winner, hex_p1, hex_p2
  );

  modport slave (
    input  win_p1, win_p2, start,
    output round_reset, match_over, winner, hex_p1, hex_p2
  );
endinterface

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - 3-bit value to active-low seven-segment pattern
module seg7_digit
  import tow_pkg::*;
(
  input  logic [2:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_DIGIT[i_digit];

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - best-of-N match sequencer: scores, winner hold, playfield clear
module match_controller
  import tow_pkg::*;
#(
  parameter int WINS_TO_MATCH = 3,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  match_controller_if.slave  bus
);

  localparam logic [2:0]  W_TARGET    = 3'(WINS_TO_MATCH);
  localparam logic [15:0] W_HOLD_LAST = 16'(HOLD_CYCLES - 1);

  match_state_t r_state;
  logic [2:0]   r_score_p1;
  logic [2:0]   r_score_p2;
  logic [15:0]  r_hold_cnt;
  logic         r_round_reset;
  logic         r_match_over;
  logic [1:0]   r_winner;

  logic       w_p1_only;
  logic       w_p2_only;
  logic       w_draw;
  logic [2:0] w_p1_inc;
  logic [2:0] w_p2_inc;

  assign w_p1_only = bus.win_p1 & ~bus.win_p2;
  assign w_p2_only = bus.win_p2 & ~bus.win_p1;
  assign w_draw    = bus.win_p1 & bus.win_p2;
  // Saturate at the target so a score can never wrap past it.
  assign w_p1_inc  = (r_score_p1 >= W_TARGET) ? r_score_p1 : r_score_p1 + 3'd1;
  assign w_p2_inc  = (r_score_p2 >= W_TARGET) ? r_score_p2 : r_score_p2 + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= PLAY;
      r_score_p1    <= 3'd0;
      r_score_p2    <= 3'd0;
      r_hold_cnt    <= 16'd0;
      r_round_reset <= 1'b0;
      r_match_over  <= 1'b0;
      r_winner      <= WINNER_NONE;
    end else begin
      r_round_reset <= 1'b0;
      case (r_state)
        PLAY: begin
          if (w_draw) begin
            r_winner      <= WINNER_NONE;
            r_round_reset <= 1'b1;
            r_state       <= CLEAR;
          end else if (w_p1_only) begin
            r_score_p1 <= w_p1_inc;
            r_winner   <= WINNER_P1;
            r_hold_cnt <= 16'd0;
            if (w_p1_inc == W_TARGET) begin
              r_match_over <= 1'b1;
              r_state      <= MATCH_OVER;
            end else begin
              r_state <= HOLD;
            end
          end else if (w_p2_only) begin
            r_score_p2 <= w_p2_inc;
            r_winner   <= WINNER_P2;
            r_hold_cnt <= 16'd0;
            if (w_p2_inc == W_TARGET) begin
              r_match_over <= 1'b1;
              r_state      <= MATCH_OVER;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          // round_reset and the cleared winner are registered on the way into CLEAR
          // so they line up exactly with the CLEAR cycle.
          if (r_hold_cnt == W_HOLD_LAST) begin
            r_winner      <= WINNER_NONE;
            r_round_reset <= 1'b1;
            r_state       <= CLEAR;
          end else begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end
        CLEAR: begin
          r_state <= PLAY;
        end
        MATCH_OVER: begin
          if (bus.start) begin
            r_score_p1    <= 3'd0;
            r_score_p2    <= 3'd0;
            r_winner      <= WINNER_NONE;
            r_match_over  <= 1'b0;
            r_round_reset <= 1'b1;
            r_state       <= CLEAR;
          end
        end
        default: begin
          r_state <= PLAY;
        end
      endcase
    end
  end

  assign bus.round_reset = r_round_reset;
  assign bus.match_over  = r_match_over;
  assign bus.winner      = r_winner;

  seg7_digit u_hex_p1 (
    .i_digit (r_score_p1),
    .o_seg   (bus.hex_p1)
  );

  seg7_digit u_hex_p2 (
    .i_digit (r_score_p2),
    .o_seg   (bus.hex_p2)
  );

endmodule

// File: doc/match_controller.md
# match_controller

Best-of-N match sequencer for the tug-of-war game. It consumes the latched per-round winner flags from the round victory detector, keeps per-player round scores, and holds the winner display for a fixed time. It then pulses a playfield clear for the next round and declares the match over once a player reaches the win target. It sits between the round-level game logic (playfield LEDs + victory detector) and the board HEX displays.

## Interface
- WINS_TO_MATCH, default 3: rounds needed to win the match; legal range 1..7.
- HOLD_CYCLES, default 4: cycles the round result is held before the playfield is cleared; legal range ≥1 (board build uses a divided clock, so small values are fine).
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- win_p1  input  1  level; round won by player 1. Stays high until the upstream block is cleared by round_reset.
- win_p2  input  1  level; round won by player 2. Same behaviour as win_p1.
- start  input  1  single-cycle pulse from a synchronised, edge-detected button; begins a new match from MATCH_OVER only.
- round_reset  output  1  registered; high for exactly one cycle to clear the playfield and victory detector.
- match_over  output  1  registered; high while in MATCH_OVER.
- winner  output  2  registered; 2'b01 = player 1, 2'b10 = player 2, 2'b00 = none. Shows the last round winner during HOLD, and the match winner during MATCH_OVER.
- hex_p1  output  7  active-low seven-segment digit of player 1 score.
- hex_p2  output  7  active-low seven-segment digit of player 2 score.

## Operation
- States: PLAY, HOLD, CLEAR, MATCH_OVER.
- Reset (async, reset_n low) drives the following: state PLAY, score_p1 = score_p2 = 0, hold counter 0, round_reset 0, match_over 0, winner 00, hex_p1 = hex_p2 = 7'b1000000.
- PLAY: win_p1 & ~win_p2 increments score_p1 and sets winner 01. ~win_p1 & win_p2 increments score_p2 and sets winner 10. Both inputs high is a draw: no score change, winner 00, go to CLEAR. Neither high: stay in PLAY.
- After an increment:
  - If the new score equals WINS_TO_MATCH, go to MATCH_OVER.
  - Otherwise go to HOLD with the counter loaded to 0.
- HOLD: counter increments each cycle. When the counter equals HOLD_CYCLES-1, go to CLEAR. Win inputs are ignored.
- CLEAR: round_reset = 1 for this one cycle, winner returns to 00, next state PLAY. Win inputs are ignored.
- MATCH_OVER: match_over = 1, winner holds the match winner, scores are frozen, and win inputs are ignored. A start pulse zeroes both scores, clears winner and match_over, and goes to CLEAR.
- start is ignored in PLAY, HOLD and CLEAR.
- Scores are 3-bit, saturating at WINS_TO_MATCH; they never wrap.
- The hex outputs are combinational decodes of the registered scores, with digits 0–7 encoded as:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000

## Timing
- A win input sampled high at edge N in PLAY gives the updated score, winner and new state visible after edge N.
- HOLD lasts exactly HOLD_CYCLES cycles. CLEAR lasts exactly 1 cycle. round_reset is high for exactly the cycle state==CLEAR.
- The upstream detector resets synchronously on round_reset, so its win outputs are low from the first PLAY cycle after CLEAR. No stale win is re-counted.
- Round latency from a win edge to the next PLAY is HOLD_CYCLES+1 cycles.
- reset_n asserted mid-HOLD or mid-CLEAR aborts immediately to the reset values; a round_reset pulse in progress is truncated.
- A start pulse coincident with a win input in MATCH_OVER: start wins and the win is ignored.

## Structure
- Shared package `tow_pkg` holds:
  - the state enum `match_state_t`
  - the `WINNER_NONE/P1/P2` 2-bit constants
  - the `SEG_DIGIT[0:7]` active-low segment constant array (reused by other HEX drivers).
- One sub-module is required: `seg7_digit`, a 3-bit to 7-bit active-low decode, instantiated twice.
- The FSM, hold counter and score registers live in `match_controller`.

## Test plan
- Async reset mid-HOLD: assert reset_n=0 between edges → outputs read winner=00, scores 0, hex both 1000000 before the next clk edge.
- Single round: win_p1=1 for one cycle in PLAY (HOLD_CYCLES=4) → score_p1=1, hex_p1=1111001, winner=01 for 4 cycles, then round_reset=1 for one cycle, then PLAY with winner=00.
- Draw: win_p1=win_p2=1 in PLAY → scores unchanged, next cycle round_reset=1, then PLAY.
- Wins ignored outside PLAY: hold win_p2=1 through HOLD and CLEAR after a p1 win → score_p2 stays 0.
- Match end: p2 wins 3 rounds (WINS_TO_MATCH=3) → hex_p2=0110000, match_over=1, winner=10, no round_reset; further wins are ignored.
- Restart: start pulse in MATCH_OVER → scores 0, hex both 1000000, match_over=0, round_reset=1 next cycle; a start pulse in PLAY has no effect.
